// File: rtl/tick_period_monitor_if.sv
// Bundles the tick monitor's control inputs and health outputs.
// master drives stimulus and reads status; slave is the monitor.
interface tick_period_monitor_if #(
  parameter int CBITS = 13,
  parameter int KBITS = 8
);
  logic             i_en;
  logic             i_tick_in;
  logic             i_clr_err;
  logic [CBITS-1:0] o_period;
  logic             o_period_vld;
  logic             o_early_err;
  logic             o_late_err;
  logic             o_err_sticky;
  logic             o_locked;
  logic [KBITS-1:0] o_good_cnt;

  modport master (
    output i_en, i_tick_in, i_clr_err,
    input  o_period, o_period_vld, o_early_err, o_late_err,
           o_err_sticky, o_locked, o_good_cnt
  );

  modport slave (
    input  i_en, i_tick_in, i_clr_err,
    output o_period, o_period_vld, o_early_err, o_late_err,
           o_err_sticky, o_locked, o_good_cnt
  );
endinterface

// File: rtl/tick_period_monitor.sv
// Measures cycles between upstream ticks, flags early/late periods,
// and reports lock status plus a saturating good-period count.
module tick_period_monitor #(
  parameter int EXP_PERIOD = 5001,
  parameter int TOL        = 2,
  parameter int LOCK_CNT   = 4,
  parameter int CBITS      = 13,
  parameter int KBITS      = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  tick_period_monitor_if.slave bus
);
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SYNC  = 2'd1;
  localparam logic [1:0] ST_TRACK = 2'd2;

  localparam int               RBITS    = $clog2(LOCK_CNT + 1);
  localparam logic [CBITS-1:0] WIN_LO   = CBITS'(EXP_PERIOD - TOL);
  localparam logic [CBITS-1:0] WIN_HI   = CBITS'(EXP_PERIOD + TOL);
  localparam logic [CBITS-1:0] CNT_ONE  = CBITS'(1);
  localparam logic [RBITS-1:0] RUN_MAX  = RBITS'(LOCK_CNT);
  localparam logic [RBITS-1:0] RUN_PRE  = RBITS'(LOCK_CNT - 1);
  localparam logic [RBITS-1:0] RUN_ONE  = RBITS'(1);
  localparam logic [KBITS-1:0] GOOD_MAX = '1;
  localparam logic [KBITS-1:0] GOOD_ONE = KBITS'(1);

  logic [1:0]       r_state;
  logic [CBITS-1:0] r_cnt;
  logic [CBITS-1:0] r_period;
  logic [RBITS-1:0] r_run;
  logic             r_period_vld;
  logic             r_early_err;
  logic             r_late_err;
  logic             r_err_sticky;
  logic             r_locked;
  logic [KBITS-1:0] r_good_cnt;
  logic             w_short;

  assign w_short = (r_cnt < WIN_LO);

  // Clearing err_sticky comes first so a same-cycle error set overrides it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_period     <= '0;
      r_run        <= '0;
      r_period_vld <= 1'b0;
      r_early_err  <= 1'b0;
      r_late_err   <= 1'b0;
      r_err_sticky <= 1'b0;
      r_locked     <= 1'b0;
      r_good_cnt   <= '0;
    end else begin
      r_period_vld <= 1'b0;
      r_early_err  <= 1'b0;
      r_late_err   <= 1'b0;
      if (bus.i_clr_err)
        r_err_sticky <= 1'b0;
      if (!bus.i_en) begin
        r_state  <= ST_IDLE;
        r_cnt    <= '0;
        r_run    <= '0;
        r_locked <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_state <= ST_SYNC;
            r_cnt   <= '0;
          end
          ST_SYNC: begin
            if (bus.i_tick_in) begin
              r_state <= ST_TRACK;
              r_cnt   <= CNT_ONE;
            end
          end
          ST_TRACK: begin
            if (bus.i_tick_in) begin
              r_period     <= r_cnt;
              r_period_vld <= 1'b1;
              r_cnt        <= CNT_ONE;
              if (w_short) begin
                r_early_err  <= 1'b1;
                r_err_sticky <= 1'b1;
                r_run        <= '0;
                r_locked     <= 1'b0;
              end else begin
                if (r_run != RUN_MAX)
                  r_run <= r_run + RUN_ONE;
                if (r_run >= RUN_PRE)
                  r_locked <= 1'b1;
                if (r_good_cnt != GOOD_MAX)
                  r_good_cnt <= r_good_cnt + GOOD_ONE;
              end
            end else if (r_cnt == WIN_HI) begin
              // Window closed with no tick: resynchronise on the next one.
              r_late_err   <= 1'b1;
              r_err_sticky <= 1'b1;
              r_run        <= '0;
              r_locked     <= 1'b0;
              r_state      <= ST_SYNC;
              r_cnt        <= '0;
            end else begin
              r_cnt <= r_cnt + CNT_ONE;
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end
        endcase
      end
    end
  end

  assign bus.o_period     = r_period;
  assign bus.o_period_vld = r_period_vld;
  assign bus.o_early_err  = r_early_err;
  assign bus.o_late_err   = r_late_err;
  assign bus.o_err_sticky = r_err_sticky;
  assign bus.o_locked     = r_locked;
  assign bus.o_good_cnt   = r_good_cnt;
endmodule

// File: tb/tb_tick_period_monitor.sv
// Self-checking bench: reset/startup vector table, directed corner sequences,
// and randomized tick gaps, all cross-checked against a time-based model.
module tb_tick_period_monitor;
  localparam int EXP  = 5001;
  localparam int TOL  = 2;
  localparam int LOCK = 4;
  localparam int CB   = 13;
  localparam int KB   = 8;
  localparam int LO   = EXP - TOL;
  localparam int HI   = EXP + TOL;
  localparam int GMAX = (1 << KB) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   assertCount = 0;
  int   failCount   = 0;

  tick_period_monitor_if #(.CBITS(CB), .KBITS(KB)) bus ();

  tick_period_monitor #(
    .EXP_PERIOD(EXP), .TOL(TOL), .LOCK_CNT(LOCK), .CBITS(CB), .KBITS(KB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    logic  r, e, t, c;
    int    period;
    logic  vld, early, late, sticky, locked;
    int    good;
  } vec_t;

  vec_t vecs[9];

  // Reference model: measures periods as differences of absolute tick times.
  int mT = 0, mMode = 0, mRef = 0, mStreak = 0, mGood = 0, mPeriod = 0;
  bit mVld = 0, mEarly = 0, mLate = 0, mSticky = 0, mLocked = 0;

  task automatic modelStep();
    int elapsed;
    mT++;
    mVld = 0; mEarly = 0; mLate = 0;
    if (rst) begin
      mMode = 0; mStreak = 0; mGood = 0; mPeriod = 0; mSticky = 0; mLocked = 0;
    end else begin
      if (bus.i_clr_err) mSticky = 0;
      if (!bus.i_en) begin
        mMode = 0; mStreak = 0; mLocked = 0;
      end else if (mMode == 0) begin
        mMode = 1;
      end else if (mMode == 1) begin
        if (bus.i_tick_in) begin mMode = 2; mRef = mT; end
      end else begin
        elapsed = mT - mRef;
        if (bus.i_tick_in) begin
          mPeriod = elapsed; mVld = 1; mRef = mT;
          if (elapsed < LO) begin
            mEarly = 1; mSticky = 1; mStreak = 0; mLocked = 0;
          end else begin
            mStreak = (mStreak < LOCK) ? mStreak + 1 : LOCK;
            mLocked = (mStreak == LOCK);
            mGood   = (mGood < GMAX) ? mGood + 1 : GMAX;
          end
        end else if (elapsed == HI) begin
          mLate = 1; mSticky = 1; mStreak = 0; mLocked = 0; mMode = 1;
        end
      end
    end
  endtask

  always @(posedge clk) modelStep();

  function automatic logic [25:0] packOut(input int period, input bit vld, early,
                                          late, sticky, locked, input int good);
    return {CB'(period), vld, early, late, sticky, locked, KB'(good)};
  endfunction

  function automatic logic [25:0] packDut();
    return {bus.o_period, bus.o_period_vld, bus.o_early_err, bus.o_late_err,
            bus.o_err_sticky, bus.o_locked, bus.o_good_cnt};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
      if (failCount >= 20) begin
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
      end
    end
  endtask

  // Every cycle, away from the active edge, the DUT must track the model.
  always @(negedge clk)
    checkOutput("model", 64'(packDut()),
                64'(packOut(mPeriod, mVld, mEarly, mLate, mSticky, mLocked, mGood)));

  task automatic applyStimulus(input logic r, e, t, c);
    rst = r; bus.i_en = e; bus.i_tick_in = t; bus.i_clr_err = c;
    @(negedge clk);
  endtask

  task automatic tickAfter(input int p, input int clrAt);
    for (int i = 1; i <= p; i++) applyStimulus(1'b0, 1'b1, i == p, i == clrAt);
  endtask

  initial begin
    #1_500_000;
    failCount++;
    $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

  initial begin
    int kind, gap, spent;
    bus.i_en = 1'b0; bus.i_tick_in = 1'b0; bus.i_clr_err = 1'b0;

    vecs[0] = '{"rst_tick_a",   1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[1] = '{"rst_notick",   1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[2] = '{"rst_tick_b",   1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[3] = '{"idle_to_sync", 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[4] = '{"sync_tick",    0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[5] = '{"back_to_back", 0, 1, 1, 0, 1, 1, 1, 0, 1, 0, 0};
    vecs[6] = '{"clr_alone",    0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0};
    vecs[7] = '{"en_drop_tick", 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0};
    vecs[8] = '{"rst_again",    1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0};

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].r, vecs[i].e, vecs[i].t, vecs[i].c);
      checkOutput(vecs[i].name, 64'(packDut()),
                  64'(packOut(vecs[i].period, vecs[i].vld, vecs[i].early, vecs[i].late,
                              vecs[i].sticky, vecs[i].locked, vecs[i].good)));
    end

    // Nominal lock-up: the first tick only synchronises.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("sync_no_vld", 64'(bus.o_period_vld), 64'(0));
    for (int k = 1; k <= 5; k++) begin
      tickAfter(EXP, 0);
      checkOutput("nom_vld", 64'(bus.o_period_vld), 64'(1));
      checkOutput("nom_period", 64'(bus.o_period), 64'(EXP));
      checkOutput("nom_locked", 64'(bus.o_locked), 64'(k >= 4));
      checkOutput("nom_good", 64'(bus.o_good_cnt), 64'(k));
      checkOutput("nom_errs", 64'({bus.o_early_err, bus.o_late_err, bus.o_err_sticky}), 64'(0));
    end

    // Window edges, then one period just below the window.
    tickAfter(LO, 0);
    checkOutput("lo_edge_good", 64'({bus.o_period_vld, bus.o_early_err, bus.o_locked}), 64'(3'b101));
    checkOutput("lo_edge_cnt", 64'(bus.o_good_cnt), 64'(6));
    tickAfter(HI, 0);
    checkOutput("hi_edge_period", 64'(bus.o_period), 64'(HI));
    checkOutput("hi_edge_cnt", 64'(bus.o_good_cnt), 64'(7));
    tickAfter(LO - 1, 0);
    checkOutput("early_pulse", 64'({bus.o_period_vld, bus.o_early_err}), 64'(2'b11));
    checkOutput("early_period", 64'(bus.o_period), 64'(LO - 1));
    checkOutput("early_state", 64'({bus.o_locked, bus.o_err_sticky}), 64'(2'b01));
    checkOutput("early_cnt", 64'(bus.o_good_cnt), 64'(7));

    // Still tracking after the early tick; clr_err on an idle cycle clears sticky.
    tickAfter(EXP, 3);
    checkOutput("post_early_vld", 64'(bus.o_period_vld), 64'(1));
    checkOutput("clr_alone_sticky", 64'(bus.o_err_sticky), 64'(0));
    checkOutput("post_early_cnt", 64'(bus.o_good_cnt), 64'(8));

    // Timeout: late fires on the cycle after cnt reaches the window top.
    for (int i = 1; i < HI; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("late_not_yet", 64'(bus.o_late_err), 64'(0));
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("late_pulse", 64'({bus.o_late_err, bus.o_period_vld, bus.o_err_sticky}), 64'(3'b101));
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("late_one_cycle", 64'(bus.o_late_err), 64'(0));
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("resync_no_vld", 64'(bus.o_period_vld), 64'(0));
    tickAfter(EXP, 0);
    checkOutput("resync_period", 64'({bus.o_period_vld, bus.o_period}), 64'({1'b1, CB'(EXP)}));

    // clr_err coinciding with an early classification: set wins.
    tickAfter(100, 100);
    checkOutput("set_wins", 64'({bus.o_early_err, bus.o_err_sticky}), 64'(2'b11));
    checkOutput("set_wins_period", 64'(bus.o_period), 64'(100));

    // Drop en mid-measurement; held outputs keep their values.
    for (int i = 1; i < 2000; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("en_drop_hold", 64'({bus.o_period_vld, bus.o_locked, bus.o_period, bus.o_good_cnt}),
                64'({2'b00, CB'(100), KB'(9)}));
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("reenable_sync", 64'(bus.o_period_vld), 64'(0));
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("reenable_track", 64'({bus.o_period_vld, bus.o_period}), 64'({1'b1, CB'(1)}));
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("rst_mid_track", 64'(packDut()), 64'(0));

    // Randomized gaps: mostly early or in-window, with occasional timeouts and en drops.
    spent = 0;
    while (spent < 15000) begin
      kind = $urandom_range(0, 9);
      if (kind <= 4)      gap = $urandom_range(1, 300);
      else if (kind <= 7) gap = $urandom_range(LO, HI);
      else if (kind == 8) gap = HI + $urandom_range(1, 5);
      else begin
        gap = 1;
        for (int i = 0; i < $urandom_range(1, 3); i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      end
      for (int i = 1; i <= gap; i++)
        applyStimulus(1'b0, 1'b1, i == gap, $urandom_range(0, 19) == 0);
      spent += gap;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end
endmodule

// File: doc/tick_period_monitor.md
Name: tick_period_monitor

Overview:
- Sits directly downstream of the periodic delay/tick generator and consumes its single-cycle tick pulse.
- Measures the cycle distance between consecutive ticks and checks it against an expected period with tolerance.
- Reports measured period, early/late faults, a lock indication and a saturating good-period count to the system health logic.

Parameters:
EXP_PERIOD, 5001, expected clk cycles between consecutive tick pulses
TOL, 2, allowed deviation in cycles, symmetric; good window = [EXP_PERIOD-TOL, EXP_PERIOD+TOL]
LOCK_CNT, 4, consecutive good periods required to assert locked
CBITS, 13, period counter width; EXP_PERIOD+TOL must be below 2^CBITS
KBITS, 8, good-period counter width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
en  in  1  monitor enable; low forces IDLE
tick_in  in  1  single-cycle tick from upstream generator
clr_err  in  1  clears err_sticky
period  out  CBITS  last measured period, held until next measurement
period_vld  out  1  one-cycle pulse: period updated
early_err  out  1  one-cycle pulse: tick arrived before window
late_err  out  1  one-cycle pulse: window expired without tick
err_sticky  out  1  set on any early/late error
locked  out  1  LOCK_CNT consecutive good periods seen, no error since
good_cnt  out  KBITS  saturating count of good periods

Behaviour:
- Reset: rst=1 sets every output to 0, clears cnt and run counter, state=IDLE. rst has priority over all other inputs. rst mid-measurement discards the measurement; no pulses are generated.
- All outputs are registered. Pulses assert the cycle after the causing event.
- FSM states: IDLE, SYNC, TRACK.
- IDLE: cnt=0, locked=0. en=1 -> SYNC.
- SYNC: waits for the first tick. tick_in=1 -> TRACK, cnt<=1. No period_vld for this tick.
- TRACK: cnt increments each cycle, so at tick arrival cnt = cycles since previous tick.
- TRACK, tick_in=1:
  - period<=cnt, period_vld pulse, cnt<=1, stay TRACK.
  - If cnt < EXP_PERIOD-TOL: early_err pulse, err_sticky=1, run=0, locked=0.
  - Otherwise (in window): run++ saturating at LOCK_CNT; locked=1 when run reaches LOCK_CNT; good_cnt++ saturating at 2^KBITS-1.
- TRACK, no tick and cnt == EXP_PERIOD+TOL: late_err pulse, err_sticky=1, run=0, locked=0, -> SYNC. No period_vld.
- A tick exactly at cnt = EXP_PERIOD+TOL is good. A tick at cnt = EXP_PERIOD-TOL is good.
- cnt never exceeds EXP_PERIOD+TOL, so no wrap is possible.
- en=0 in any state: -> IDLE next cycle; cnt, run and locked cleared; pulses suppressed; err_sticky, period and good_cnt held. A tick in the same cycle as en falling is ignored.
- err_sticky: cleared by clr_err. If clr_err coincides with a new error event, set wins.
- Back-to-back ticks (cnt=1): classified early like any other short period.

Test Plan:
- Reset: assert rst 3 cycles with ticks toggling -> all outputs 0, state IDLE, no pulses.
- Nominal: en=1, ticks every 5001 cycles, 6 ticks -> first tick gives no period_vld; then 5 period_vld pulses with period=5001; locked=1 the cycle after the 5th tick; good_cnt=5 after 6th tick; no errors.
- Boundaries: periods 4999, 5003, 4998 from locked state -> first two good (period_vld, good_cnt++); 4998 -> early_err pulse, period=4998, locked=0, err_sticky=1, stays TRACK.
- Timeout: after a good tick, withhold ticks -> late_err pulse the cycle after cnt=5003, state SYNC, no period_vld; next tick gives no period_vld; following tick at 5001 gives period_vld with period=5001.
- clr_err: with err_sticky=1, pulse clr_err alone -> 0. Pulse clr_err on the same cycle an early tick is classified -> err_sticky stays 1.
- en/rst mid-operation: drop en in TRACK at cnt=2000 -> IDLE, locked=0, period/good_cnt held. Re-enable -> SYNC. rst mid-TRACK -> all outputs 0.
